// File: rtl/uart_host_tx.sv
// Host-side 8N1 UART transmitter: sends an autobaud preamble after reset or on request,
// then streams bytes popped from a synchronous read FIFO at a programmable clocks-per-bit rate.
module uart_host_tx #(
    parameter int          CPB_WIDTH = 12,
    parameter logic [7:0]  SYNC_CHAR = 8'h55
) (
    input  logic                 CLK,
    input  logic                 RESETn,
    input  logic [CPB_WIDTH-1:0] CPB,
    output logic                 TX_PIN,
    input  logic [7:0]           RDDATA,
    output logic                 RDEN,
    input  logic                 RDEMPTY,
    input  logic                 RESYNC,
    output logic                 BUSY,
    output logic                 SYNC_DONE
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        DATA  = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t               state, state_next;
    logic                 sync_pending, sync_pending_next;
    logic                 is_sync, is_sync_next;
    logic                 sync_done, sync_done_next;
    logic [CPB_WIDTH-1:0] timer, timer_next;
    logic [CPB_WIDTH-1:0] cpb_lat;
    logic [2:0]           bit_cnt, bit_cnt_next;
    logic [7:0]           shreg, shreg_next;
    logic                 tx_next;
    logic                 rden;
    logic                 pend_eff;
    logic                 absorb;
    logic                 bit_end;

    // Divisors below 2 cannot produce a distinguishable bit, so they are clamped.
    function automatic logic [CPB_WIDTH-1:0] clamp_cpb(input logic [CPB_WIDTH-1:0] c);
        return (c < CPB_WIDTH'(2)) ? CPB_WIDTH'(2) : c;
    endfunction

    // A request arriving before the preamble's first data bit is satisfied by that preamble.
    assign absorb   = is_sync && (state == LOAD || state == START);
    assign pend_eff = sync_pending | RESYNC;
    assign bit_end  = (timer == '0);

    always_comb begin
        state_next        = state;
        sync_pending_next = sync_pending | (RESYNC & ~absorb);
        is_sync_next      = is_sync;
        sync_done_next    = sync_done;
        timer_next        = timer;
        bit_cnt_next      = bit_cnt;
        shreg_next        = shreg;
        rden              = 1'b0;

        case (state)
            IDLE: begin
                if (pend_eff) begin
                    state_next        = LOAD;
                    is_sync_next      = 1'b1;
                    shreg_next        = SYNC_CHAR;
                    sync_pending_next = 1'b0;
                end else if (!RDEMPTY) begin
                    rden         = 1'b1;
                    state_next   = LOAD;
                    is_sync_next = 1'b0;
                end
            end
            LOAD: begin
                state_next = START;
                timer_next = clamp_cpb(CPB) - CPB_WIDTH'(1);
                if (!is_sync)
                    shreg_next = RDDATA;
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    timer_next   = cpb_lat - CPB_WIDTH'(1);
                    bit_cnt_next = 3'd0;
                end else begin
                    timer_next = timer - CPB_WIDTH'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_next = cpb_lat - CPB_WIDTH'(1);
                    if (bit_cnt == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                        shreg_next   = shreg >> 1;
                    end
                end else begin
                    timer_next = timer - CPB_WIDTH'(1);
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    if (is_sync)
                        sync_done_next = 1'b1;
                end else begin
                    timer_next = timer - CPB_WIDTH'(1);
                end
            end
            default: state_next = IDLE;
        endcase

        // Line level is registered from the upcoming state so it changes on the bit boundary edge.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[0];
            default: tx_next = 1'b1;
        endcase
    end

    // Control registers
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state        <= IDLE;
            sync_pending <= 1'b1;
            is_sync      <= 1'b0;
            sync_done    <= 1'b0;
            timer        <= '0;
            bit_cnt      <= 3'd0;
            TX_PIN       <= 1'b1;
        end else begin
            state        <= state_next;
            sync_pending <= sync_pending_next;
            is_sync      <= is_sync_next;
            sync_done    <= sync_done_next;
            timer        <= timer_next;
            bit_cnt      <= bit_cnt_next;
            TX_PIN       <= tx_next;
        end
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        shreg <= shreg_next;
        if (state == LOAD)
            cpb_lat <= clamp_cpb(CPB);
    end

    assign RDEN      = rden;
    assign BUSY      = (state != IDLE);
    assign SYNC_DONE = sync_done;

endmodule

// File: tb/tb_uart_host_tx.sv
// Directed bench for uart_host_tx: FIFO model, frame decoder and hand-computed expectations.
module tb_uart_host_tx;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic [11:0] CPB;
    logic        TX_PIN;
    logic [7:0]  RDDATA;
    logic        RDEN;
    logic        RDEMPTY;
    logic        RESYNC;
    logic        BUSY;
    logic        SYNC_DONE;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    logic [7:0] fifo_mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         pops   = 0;
    int         rden_cyc [0:63];

    uart_host_tx dut (
        .CLK       (CLK),
        .RESETn    (RESETn),
        .CPB       (CPB),
        .TX_PIN    (TX_PIN),
        .RDDATA    (RDDATA),
        .RDEN      (RDEN),
        .RDEMPTY   (RDEMPTY),
        .RESYNC    (RESYNC),
        .BUSY      (BUSY),
        .SYNC_DONE (SYNC_DONE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    assign RDEMPTY = (wr_ptr == rd_ptr);

    always @(posedge CLK) begin
        if (RDEN) begin
            RDDATA           <= fifo_mem[rd_ptr[5:0]];
            rd_ptr           <= rd_ptr + 1;
            rden_cyc[pops[5:0]] <= cyc;
            pops             <= pops + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr[5:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic rx_frame(input int cpb, input string tag, input logic [7:0] exp, output int start);
        int         guard;
        logic [7:0] d;
        guard = 0;
        d     = 8'h00;
        while (TX_PIN !== 1'b0 && guard < 4000) begin
            @(negedge CLK);
            guard++;
        end
        start = cyc;
        if (guard >= 4000) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        repeat (cpb / 2) @(negedge CLK);
        check({tag, "_start"}, 32'(TX_PIN), 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (cpb) @(negedge CLK);
            d[i] = TX_PIN;
        end
        check({tag, "_data"}, 32'(d), 32'(exp));
        repeat (cpb) @(negedge CLK);
        check({tag, "_stop"}, 32'(TX_PIN), 32'd1);
    endtask

    initial begin
        int base, s1, s2, s3, p0, lows, guard;
        RESETn = 1'b0;
        CPB    = 12'd16;
        RESYNC = 1'b0;
        RDDATA = 8'h00;
        repeat (3) @(negedge CLK);
        check("rst_tx",   32'(TX_PIN),    32'd1);
        check("rst_rden", 32'(RDEN),      32'd0);
        check("rst_busy", 32'(BUSY),      32'd0);
        check("rst_sdone",32'(SYNC_DONE), 32'd0);

        // Preamble after reset release, CPB=16, FIFO empty
        RESETn = 1'b1;
        base   = cyc;
        @(negedge CLK);
        check("e1_tx",   32'(TX_PIN), 32'd1);
        check("e1_busy", 32'(BUSY),   32'd1);
        rx_frame(16, "pre0", 8'h55, s1);
        check("pre0_edge", 32'(s1 - base), 32'd2);
        while (cyc - base < 161) @(negedge CLK);
        check("sdone_161", 32'(SYNC_DONE), 32'd0);
        @(negedge CLK);
        check("sdone_162", 32'(SYNC_DONE), 32'd1);
        check("pre0_pops", 32'(pops), 32'd0);

        // FIFO stream at CPB=8
        CPB = 12'd8;
        push(8'hA3); push(8'h00); push(8'hFF);
        rx_frame(8, "fa3", 8'hA3, s1);
        rx_frame(8, "f00", 8'h00, s2);
        rx_frame(8, "fff", 8'hFF, s3);
        check("per_12", 32'(s2 - s1), 32'd82);
        check("per_23", 32'(s3 - s2), 32'd82);
        check("pops3",  32'(pops), 32'd3);
        check("rden_12", 32'(rden_cyc[1] - rden_cyc[0]), 32'd82);
        check("rden_23", 32'(rden_cyc[2] - rden_cyc[1]), 32'd82);
        check("rden_lead", 32'(s1 - rden_cyc[0]), 32'd2);

        // RESYNC during data bits of 0x3C
        repeat (20) @(negedge CLK);
        p0 = pops;
        push(8'h3C); push(8'h11);
        fork
            begin
                repeat (34) @(negedge CLK);
                RESYNC = 1'b1;
                @(negedge CLK);
                RESYNC = 1'b0;
            end
        join_none
        rx_frame(8, "f3c", 8'h3C, s1);
        check("rs_sdone", 32'(SYNC_DONE), 32'd1);
        check("rs_pop1", 32'(pops), 32'(p0 + 1));
        rx_frame(8, "rs_pre", 8'h55, s2);
        check("rs_pop2", 32'(pops), 32'(p0 + 1));
        rx_frame(8, "f11", 8'h11, s3);
        check("rs_per1", 32'(s2 - s1), 32'd82);
        check("rs_per2", 32'(s3 - s2), 32'd82);
        check("rs_pop3", 32'(pops), 32'(p0 + 2));

        // CPB change mid-frame, then CPB=0
        repeat (10) @(negedge CLK);
        CPB = 12'd16;
        push(8'h5A); push(8'h81);
        fork
            begin
                repeat (40) @(negedge CLK);
                CPB = 12'd4;
            end
        join_none
        rx_frame(16, "f5a", 8'h5A, s1);
        rx_frame(4,  "f81", 8'h81, s2);
        check("cpb_per", 32'(s2 - s1), 32'd162);
        CPB = 12'd0;
        push(8'hC5); push(8'h3A);
        rx_frame(2, "fc5", 8'hC5, s1);
        rx_frame(2, "f3a", 8'h3A, s2);
        check("cpb0_per", 32'(s2 - s1), 32'd22);

        // Reset during bit 3 of 0x96
        repeat (10) @(negedge CLK);
        CPB = 12'd16;
        p0  = pops;
        push(8'h96); push(8'h22);
        guard = 0;
        while (TX_PIN !== 1'b0 && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        check("f96_seen", 32'(guard < 200), 32'd1);
        repeat (16 + 3 * 16 + 8) @(negedge CLK);
        check("f96_bit3", 32'(TX_PIN), 32'd0);
        #2 RESETn = 1'b0;
        #1;
        check("ar_tx",    32'(TX_PIN),    32'd1);
        check("ar_busy",  32'(BUSY),      32'd0);
        check("ar_sdone", 32'(SYNC_DONE), 32'd0);
        check("ar_rden",  32'(RDEN),      32'd0);
        @(negedge CLK);
        RESETn = 1'b1;
        base   = cyc;
        check("ar_pops", 32'(pops), 32'(p0 + 1));
        rx_frame(16, "ar_pre", 8'h55, s1);
        check("ar_edge", 32'(s1 - base), 32'd2);
        check("ar_pops2", 32'(pops), 32'(p0 + 1));
        rx_frame(16, "f22", 8'h22, s2);
        check("ar_pops3", 32'(pops), 32'(p0 + 2));

        // Three back-to-back RESYNC pulses while idle
        repeat (20) @(negedge CLK);
        CPB = 12'd8;
        p0  = pops;
        fork
            begin
                RESYNC = 1'b1;
                repeat (3) @(negedge CLK);
                RESYNC = 1'b0;
            end
        join_none
        rx_frame(8, "tri_pre", 8'h55, s1);
        lows = 0;
        repeat (200) begin
            @(negedge CLK);
            if (TX_PIN !== 1'b1) lows++;
        end
        check("tri_once", 32'(lows), 32'd0);
        check("tri_busy", 32'(BUSY), 32'd0);
        check("tri_pops", 32'(pops), 32'(p0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
